adc_acq_scheduler: RTL and testbench
====================================

// Module: adc_acq_scheduler
// PURPOSE
//  Arbitrates one shared SAR ADC between the EMG acquisition path and the BioZ readout path.
//  Sequences each conversion: grant, start pulse, fixed conversion window, data capture, ack.
//  Defers EMG conversions while a stimulation pulse is active, plus a settling tail.
//  Sits between the EMG/BioZ stimulus controllers and the ADC/input-mux in the acquisition top level.
// PARAMETERS
//  ADC_BITS     10  width of ADC result
//  CONV_CYCLES  13  ADC clock cycles per conversion (>=1)
//  CH_W         4   EMG channel-select width
//  BLANK_TAIL   20  cycles EMG stays blanked after stim_active falls (0 = no tail)
// PORTS
//  clk_ADC       in   1         ADC clock; all logic on rising edge
//  Resetn        in   1         synchronous reset, active low
//  enable        in   1         scheduler enable
//  req_emg       in   1         EMG conversion request (level, held until ack_emg)
//  ch_emg        in   CH_W      EMG channel for the request
//  req_bioz      in   1         BioZ conversion request (level, held until ack_bioz)
//  stim_active   in   1         OR of CAT/ANO/DIS stimulation phases
//  adc_dout      in   ADC_BITS  ADC result, valid in last CONV cycle
//  adc_en        out  1         ADC enable
//  adc_start     out  1         one-cycle conversion start
//  adc_src       out  1         input mux: 0=EMG, 1=BioZ
//  adc_ch        out  CH_W      latched EMG channel (0 for BioZ)
//  ack_emg       out  1         one-cycle completion for EMG
//  ack_bioz      out  1         one-cycle completion for BioZ
//  data_out      out  ADC_BITS  captured result, valid with ack, held until next capture
//  data_blanked  out  1         result overlapped a blanking window; valid with ack
//  blank         out  1         EMG blanking active
// BEHAVIOUR
//  Reset (Resetn=0 at edge): state=IDLE; all outputs 0; last_src=1 (EMG wins first tie); tail cnt=0.
//  adc_en = registered enable; every other output is registered.
//  FSM: IDLE -> START -> CONV -> DONE -> IDLE.
//   IDLE: if enable & eligible request: latch adc_src/adc_ch -> START. Else stay.
//   START: adc_start=1 for exactly this cycle -> CONV; counter loads CONV_CYCLES-1.
//   CONV: counter decrements; when it reaches 0, capture adc_dout into data_out -> DONE.
//   DONE: ack_emg or ack_bioz =1 (per adc_src) for this cycle -> IDLE.
//  Latency: request sampled in IDLE at cycle 0 -> adc_start at cycle 1 -> ack at cycle CONV_CYCLES+2.
//  Eligibility: EMG eligible iff req_emg & ~blank; BioZ eligible iff req_bioz.
//  Both eligible: grant the source != last_src; last_src updates on every grant.
//  Requester deasserts req the cycle after ack. The source just acked is masked in the first IDLE cycle.
//  A request dropped before grant is withdrawn silently.
//  blank: 1 while stim_active=1; after the fall, stays 1 for BLANK_TAIL cycles. Re-rise reloads the tail.
//  EMG conversion already in START/CONV when blank rises runs to completion.
//  data_blanked=1 if blank was 1 in any cycle from START through the capture cycle.
//  enable=0 in START/CONV/DONE: abort to IDLE next cycle, no ack, adc_start=0.
//  data_out retains its last value on abort.
//  Counter width: clog2(CONV_CYCLES+1); no wrap because CONV exits at 0.
// CONFIGURATION
//  ACQ_STIM_BLANK_EN defined: blanking logic as above.
//  ACQ_STIM_BLANK_EN undefined: stim_active ignored; blank=0 and data_blanked=0 always.
//   EMG eligible whenever req_emg=1.
// TESTING
//  Single EMG req ch=5, adc_dout=0x2A5 -> adc_start at cycle 1, adc_src=0, adc_ch=5;
//   ack_emg at cycle 15, data_out=0x2A5.
//  req_emg and req_bioz held together from reset -> grants EMG, BioZ, EMG, BioZ; ack every 16 cycles.
//  stim_active high for 100 cycles, req_emg pending -> no EMG grant until 20 cycles after fall.
//   With req_bioz also pending, BioZ is served meanwhile.
//  stim_active rises mid EMG conversion -> conversion completes; ack_emg with data_blanked=1.
//  enable dropped in CONV cycle 5 -> FSM to IDLE, no ack. Re-enable with req held -> fresh full conversion.
//  Resetn=0 mid CONV -> next edge all outputs 0, state IDLE.
//   Build without ACQ_STIM_BLANK_EN: stim_active ignored, blank stays 0.

Source files
------------

// File: rtl/adc_acq_scheduler.sv
// adc_acq_scheduler
// Shares one SAR ADC between the EMG acquisition path and the BioZ readout
// path. Each conversion runs grant -> start pulse -> fixed conversion window
// -> capture -> ack. EMG requests are held off while stimulation is active
// and for a settling tail afterwards.
//
// Build option: define ACQ_STIM_BLANK_EN to enable stimulation blanking.
// Without it stim_active is ignored and blank/data_blanked stay 0.

module adc_acq_scheduler #(
   parameter int ADC_BITS    = 10,
   parameter int CONV_CYCLES = 13,
   parameter int CH_W        = 4,
   parameter int BLANK_TAIL  = 20
) (
   input  logic                clk_ADC,
   input  logic                Resetn,
   input  logic                enable,
   input  logic                req_emg,
   input  logic [CH_W-1:0]     ch_emg,
   input  logic                req_bioz,
   input  logic                stim_active,
   input  logic [ADC_BITS-1:0] adc_dout,
   output logic                adc_en,
   output logic                adc_start,
   output logic                adc_src,
   output logic [CH_W-1:0]     adc_ch,
   output logic                ack_emg,
   output logic                ack_bioz,
   output logic [ADC_BITS-1:0] data_out,
   output logic                data_blanked,
   output logic                blank
);

   localparam int CNT_W  = $clog2(CONV_CYCLES + 1);
   localparam int TAIL_W = (BLANK_TAIL > 0) ? $clog2(BLANK_TAIL + 1) : 1;

   localparam logic SRC_EMG  = 1'b0;
   localparam logic SRC_BIOZ = 1'b1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      CONV  = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t state, state_nxt;

   // Internal registers
   logic [CNT_W-1:0]    conv_cnt, conv_cnt_nxt;
   logic [TAIL_W-1:0]   tail_cnt, tail_nxt;
   logic                last_src, last_src_nxt;
   logic                blank_seen, blank_seen_nxt;
   logic                mask_vld, mask_vld_nxt;
   logic                blank_nxt;

   // Next values of the registered outputs
   logic                adc_start_nxt;
   logic                adc_src_nxt;
   logic [CH_W-1:0]     adc_ch_nxt;
   logic                ack_emg_nxt;
   logic                ack_bioz_nxt;
   logic [ADC_BITS-1:0] data_out_nxt;
   logic                data_blanked_nxt;

   // Arbitration helpers
   logic                emg_elig;
   logic                bioz_elig;
   logic                pick_bioz;

`ifdef ACQ_STIM_BLANK_EN
   // Blanking window: held while stimulating, then a reloadable settling tail
   always_comb begin
      blank_nxt = 1'b0;
      tail_nxt  = tail_cnt;
      if (stim_active) begin
         blank_nxt = 1'b1;
         tail_nxt  = TAIL_W'(BLANK_TAIL);
      end else if (tail_cnt != '0) begin
         blank_nxt = 1'b1;
         tail_nxt  = tail_cnt - TAIL_W'(1);
      end
   end
`else
   logic unused_stim;
   assign unused_stim = stim_active;
   assign blank_nxt   = 1'b0;
   assign tail_nxt    = '0;
`endif

   // Request eligibility; the source acked last is masked for one IDLE cycle
   // because its requester only drops the level one cycle after the ack
   always_comb begin
      emg_elig  = req_emg & ~blank & ~(mask_vld & (adc_src == SRC_EMG));
      bioz_elig = req_bioz & ~(mask_vld & (adc_src == SRC_BIOZ));
      pick_bioz = bioz_elig & (~emg_elig | (last_src == SRC_EMG));
   end

   // Sequencer next-state and registered-output next values
   always_comb begin
      state_nxt        = state;
      adc_start_nxt    = 1'b0;
      adc_src_nxt      = adc_src;
      adc_ch_nxt       = adc_ch;
      ack_emg_nxt      = 1'b0;
      ack_bioz_nxt     = 1'b0;
      data_out_nxt     = data_out;
      data_blanked_nxt = data_blanked;
      conv_cnt_nxt     = conv_cnt;
      blank_seen_nxt   = blank_seen;
      last_src_nxt     = last_src;
      mask_vld_nxt     = 1'b0;

      case (state)
         IDLE: begin
            if (enable && (emg_elig || bioz_elig)) begin
               adc_src_nxt    = pick_bioz;
               adc_ch_nxt     = pick_bioz ? '0 : ch_emg;
               last_src_nxt   = pick_bioz;
               adc_start_nxt  = 1'b1;
               blank_seen_nxt = 1'b0;
               state_nxt      = START;
            end
         end

         START: begin
            if (!enable) begin
               state_nxt = IDLE;
            end else begin
               conv_cnt_nxt   = CNT_W'(CONV_CYCLES - 1);
               blank_seen_nxt = blank;
               state_nxt      = CONV;
            end
         end

         CONV: begin
            if (!enable) begin
               state_nxt = IDLE;
            end else if (conv_cnt == '0) begin
               data_out_nxt     = adc_dout;
               data_blanked_nxt = blank_seen | blank;
               ack_emg_nxt      = (adc_src == SRC_EMG);
               ack_bioz_nxt     = (adc_src == SRC_BIOZ);
               state_nxt        = DONE;
            end else begin
               conv_cnt_nxt   = conv_cnt - CNT_W'(1);
               blank_seen_nxt = blank_seen | blank;
            end
         end

         DONE: begin
            mask_vld_nxt = 1'b1;
            state_nxt    = IDLE;
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // FSM state register
   always_ff @(posedge clk_ADC) begin
      if (!Resetn) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Output, counter and bookkeeping registers
   always_ff @(posedge clk_ADC) begin
      if (!Resetn) begin
         adc_en       <= 1'b0;
         adc_start    <= 1'b0;
         adc_src      <= 1'b0;
         adc_ch       <= '0;
         ack_emg      <= 1'b0;
         ack_bioz     <= 1'b0;
         data_out     <= '0;
         data_blanked <= 1'b0;
         blank        <= 1'b0;
         conv_cnt     <= '0;
         tail_cnt     <= '0;
         last_src     <= SRC_BIOZ;
         blank_seen   <= 1'b0;
         mask_vld     <= 1'b0;
      end else begin
         adc_en       <= enable;
         adc_start    <= adc_start_nxt;
         adc_src      <= adc_src_nxt;
         adc_ch       <= adc_ch_nxt;
         ack_emg      <= ack_emg_nxt;
         ack_bioz     <= ack_bioz_nxt;
         data_out     <= data_out_nxt;
         data_blanked <= data_blanked_nxt;
         blank        <= blank_nxt;
         conv_cnt     <= conv_cnt_nxt;
         tail_cnt     <= tail_nxt;
         last_src     <= last_src_nxt;
         blank_seen   <= blank_seen_nxt;
         mask_vld     <= mask_vld_nxt;
      end
   end

endmodule

// File: tb/tb_adc_acq_scheduler.sv
// tb_adc_acq_scheduler
// Scoreboard bench for adc_acq_scheduler: the stimulus process pushes the
// expected start pulses and acks, a monitor pops and compares them whenever
// the DUT raises adc_start or an ack. Expectations follow ACQ_STIM_BLANK_EN.

module tb_adc_acq_scheduler;

   localparam int ADC_BITS = 10;
   localparam int CH_W     = 4;

`ifdef ACQ_STIM_BLANK_EN
   localparam logic BLK = 1'b1;
`else
   localparam logic BLK = 1'b0;
`endif

   logic                clk_ADC = 1'b0;
   logic                Resetn;
   logic                enable;
   logic                req_emg;
   logic [CH_W-1:0]     ch_emg;
   logic                req_bioz;
   logic                stim_active;
   logic [ADC_BITS-1:0] adc_dout;
   logic                adc_en;
   logic                adc_start;
   logic                adc_src;
   logic [CH_W-1:0]     adc_ch;
   logic                ack_emg;
   logic                ack_bioz;
   logic [ADC_BITS-1:0] data_out;
   logic                data_blanked;
   logic                blank;

   typedef struct {
      logic            src;
      logic [CH_W-1:0] ch;
      int              cyc;
   } start_t;

   typedef struct {
      logic                src;
      logic [ADC_BITS-1:0] data;
      logic                blanked;
      int                  cyc;
   } ack_t;

   start_t start_q[$];
   ack_t   ack_q[$];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [ADC_BITS-1:0] dout_const = '0;
   logic [ADC_BITS-1:0] pat_val = '0;
   logic                dout_pattern = 1'b0;
   logic [ADC_BITS-1:0] last_data;

   adc_acq_scheduler #(
      .ADC_BITS    (ADC_BITS),
      .CONV_CYCLES (13),
      .CH_W        (CH_W),
      .BLANK_TAIL  (20)
   ) dut (
      .clk_ADC      (clk_ADC),
      .Resetn       (Resetn),
      .enable       (enable),
      .req_emg      (req_emg),
      .ch_emg       (ch_emg),
      .req_bioz     (req_bioz),
      .stim_active  (stim_active),
      .adc_dout     (adc_dout),
      .adc_en       (adc_en),
      .adc_start    (adc_start),
      .adc_src      (adc_src),
      .adc_ch       (adc_ch),
      .ack_emg      (ack_emg),
      .ack_bioz     (ack_bioz),
      .data_out     (data_out),
      .data_blanked (data_blanked),
      .blank        (blank)
   );

   always #5 clk_ADC = ~clk_ADC;

   // Cycle index: number of rising edges seen so far
   always @(posedge clk_ADC) cyc <= cyc + 1;

   function automatic logic [ADC_BITS-1:0] pat(input int k);
      return ADC_BITS'(k * 37 + 11);
   endfunction

   // Pattern source changes away from the rising edge so captures are stable
   always @(negedge clk_ADC) pat_val <= pat(cyc);

   assign adc_dout = dout_pattern ? pat_val : dout_const;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic report_fail(input string name);
      total++;
      bad++;
      $display("[TB] FAIL %s: got an output event expected none (cyc %0d)", name, cyc);
   endtask

   task automatic apply_stimulus(input logic re, input logic [CH_W-1:0] ch, input logic rb);
      req_emg  = re;
      ch_emg   = ch;
      req_bioz = rb;
   endtask

   // Expect a full conversion whose request is sampled at cycle g
   task automatic push_conv(input logic src, input logic [CH_W-1:0] ch,
                            input logic [ADC_BITS-1:0] data, input logic blanked, input int g);
      start_t s;
      ack_t   a;
      s.src = src;  s.ch = ch;  s.cyc = g + 1;
      a.src = src;  a.data = data;  a.blanked = blanked;  a.cyc = g + 15;
      start_q.push_back(s);
      ack_q.push_back(a);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_output({tag, "_adc_en"},       32'(adc_en),       32'd0);
      check_output({tag, "_adc_start"},    32'(adc_start),    32'd0);
      check_output({tag, "_adc_src"},      32'(adc_src),      32'd0);
      check_output({tag, "_adc_ch"},       32'(adc_ch),       32'd0);
      check_output({tag, "_ack_emg"},      32'(ack_emg),      32'd0);
      check_output({tag, "_ack_bioz"},     32'(ack_bioz),     32'd0);
      check_output({tag, "_data_out"},     32'(data_out),     32'd0);
      check_output({tag, "_data_blanked"}, 32'(data_blanked), 32'd0);
      check_output({tag, "_blank"},        32'(blank),        32'd0);
   endtask

   task automatic apply_reset();
      @(negedge clk_ADC);
      Resetn      = 1'b0;
      enable      = 1'b1;
      stim_active = 1'b0;
      apply_stimulus(1'b0, '0, 1'b0);
      repeat (2) @(negedge clk_ADC);
      check_reset_outputs("reset");
      Resetn = 1'b1;
   endtask

   // Monitor: compare every start pulse and ack against the scoreboard
   always @(negedge clk_ADC) begin : monitor
      start_t s;
      ack_t   a;
      if (adc_start) begin
         if (start_q.size() == 0) begin
            report_fail("unexpected_start");
         end else begin
            s = start_q.pop_front();
            check_output("start_cycle", 32'(cyc),     32'(s.cyc));
            check_output("start_src",   32'(adc_src), 32'(s.src));
            check_output("start_ch",    32'(adc_ch),  32'(s.ch));
         end
      end
      if (ack_emg && ack_bioz) begin
         report_fail("double_ack");
      end
      if (ack_emg || ack_bioz) begin
         if (ack_q.size() == 0) begin
            report_fail("unexpected_ack");
         end else begin
            a = ack_q.pop_front();
            check_output("ack_cycle",    32'(cyc),          32'(a.cyc));
            check_output("ack_src",      32'(ack_bioz),     32'(a.src));
            check_output("ack_data",     32'(data_out),     32'(a.data));
            check_output("ack_blanked",  32'(data_blanked), 32'(a.blanked));
         end
      end
   end

   initial begin
      int c0;
      int c1;
      int emg_grant;
      int emg_drop;

      Resetn      = 1'b0;
      enable      = 1'b0;
      stim_active = 1'b0;
      apply_stimulus(1'b0, '0, 1'b0);

      // Single EMG conversion on channel 5
      apply_reset();
      @(negedge clk_ADC);
      check_output("adc_en_on", 32'(adc_en), 32'd1);
      dout_const = 10'h2A5;
      apply_stimulus(1'b1, 4'd5, 1'b0);
      c0 = cyc;
      push_conv(1'b0, 4'd5, 10'h2A5, 1'b0, c0);
      repeat (15) @(negedge clk_ADC);
      req_emg = 1'b0;
      repeat (3) @(negedge clk_ADC);
      check_output("data_hold_idle", 32'(data_out), 32'h2A5);

      // Both requests held from reset: EMG, BioZ, EMG, BioZ every 16 cycles
      apply_reset();
      @(negedge clk_ADC);
      dout_pattern = 1'b1;
      apply_stimulus(1'b1, 4'd3, 1'b1);
      c0 = cyc;
      for (int k = 0; k < 4; k++) begin
         push_conv(1'(k % 2), (k % 2 == 1) ? 4'd0 : 4'd3, pat(c0 + 16 * k + 14), 1'b0, c0 + 16 * k);
      end
      last_data = pat(c0 + 62);
      repeat (63) @(negedge clk_ADC);
      apply_stimulus(1'b0, '0, 1'b0);
      repeat (20) @(negedge clk_ADC);

      // Enable dropped in the fifth conversion cycle, then re-enabled
      @(negedge clk_ADC);
      dout_pattern = 1'b0;
      dout_const   = 10'h155;
      apply_stimulus(1'b1, 4'd9, 1'b0);
      c0 = cyc;
      start_q.push_back('{1'b0, 4'd9, c0 + 1});
      repeat (6) @(negedge clk_ADC);
      enable = 1'b0;
      @(negedge clk_ADC);
      check_output("adc_en_off", 32'(adc_en), 32'd0);
      repeat (2) @(negedge clk_ADC);
      check_output("data_hold_abort", 32'(data_out), 32'(last_data));
      enable = 1'b1;
      c1 = cyc;
      push_conv(1'b0, 4'd9, 10'h155, 1'b0, c1);
      repeat (15) @(negedge clk_ADC);
      req_emg = 1'b0;
      repeat (3) @(negedge clk_ADC);

      // Reset in the middle of a BioZ conversion, then a fresh EMG request
      @(negedge clk_ADC);
      apply_stimulus(1'b0, '0, 1'b1);
      c0 = cyc;
      start_q.push_back('{1'b1, 4'd0, c0 + 1});
      repeat (5) @(negedge clk_ADC);
      Resetn = 1'b0;
      apply_stimulus(1'b0, '0, 1'b0);
      @(negedge clk_ADC);
      check_reset_outputs("midconv_reset");
      Resetn     = 1'b1;
      dout_const = 10'h3C3;
      apply_stimulus(1'b1, 4'd12, 1'b0);
      c1 = cyc;
      push_conv(1'b0, 4'd12, 10'h3C3, 1'b0, c1);
      repeat (15) @(negedge clk_ADC);
      req_emg = 1'b0;
      repeat (3) @(negedge clk_ADC);

      // 100-cycle stimulation with EMG and BioZ pending
      @(negedge clk_ADC);
      c0 = cyc;
      emg_grant = BLK ? c0 + 121 : c0 + 18;
      emg_drop  = emg_grant + 15 - c0;
      for (int k = 0; k <= 140; k++) begin
         if (k == 0) begin
            stim_active = 1'b1;
            dout_const  = 10'h0F0;
         end
         if (k == 2) begin
            apply_stimulus(1'b1, 4'd2, 1'b1);
            push_conv(1'b1, 4'd0, 10'h0F0, BLK, c0 + 2);
            push_conv(1'b0, 4'd2, 10'h30F, 1'b0, emg_grant);
         end
         if (k == 17)       req_bioz = 1'b0;
         if (k == 20)       dout_const = 10'h30F;
         if (k == emg_drop) req_emg = 1'b0;
         if (k == 50)       check_output("blank_during_stim", 32'(blank), 32'(BLK));
         if (k == 100)      stim_active = 1'b0;
         if (k == 120)      check_output("blank_tail_end", 32'(blank), 32'(BLK));
         if (k == 121)      check_output("blank_after_tail", 32'(blank), 32'd0);
         @(negedge clk_ADC);
      end

      // Stimulation rising in the middle of an EMG conversion
      c0 = cyc;
      for (int k = 0; k <= 45; k++) begin
         if (k == 0) begin
            dout_const = 10'h1E1;
            apply_stimulus(1'b1, 4'd7, 1'b0);
            push_conv(1'b0, 4'd7, 10'h1E1, BLK, c0);
         end
         if (k == 6)  stim_active = 1'b1;
         if (k == 7)  stim_active = 1'b0;
         if (k == 8)  check_output("blank_midconv", 32'(blank), 32'(BLK));
         if (k == 15) req_emg = 1'b0;
         @(negedge clk_ADC);
      end

      check_output("starts_pending", 32'(start_q.size()), 32'd0);
      check_output("acks_pending",   32'(ack_q.size()),   32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
